// File: rtl/serial_eq_cmp.sv
// -----------------------------------------------------------------------------
// serial_eq_cmp
//
// Bit-serial equality comparator. Two WIDTH-bit operand frames arrive one bit
// pair per accepted cycle, LSB first. At the end of the frame the block reports
// overall equality, the index of the first differing bit and the number of
// differing bit pairs. All outputs are registered.
//
// Parameters:
//   WIDTH        frame length in bits (2..256)
//
// Ports:
//   clk          input   rising-edge clock
//   rst_n        input   asynchronous active-low reset
//   start        input   request a new frame; accepted only in IDLE or DONE
//   bit_valid    input   a_bit/b_bit carry a valid pair this cycle (RUN only)
//   a_bit        input   operand A serial bit, LSB first
//   b_bit        input   operand B serial bit, LSB first
//   busy         output  high while a frame is being collected
//   done         output  one-cycle pulse when results are valid
//   eq           output  1 when all WIDTH pairs matched
//   first_diff   output  index of the first mismatching bit (0 when eq=1)
//   mismatch_cnt output  number of mismatching bit pairs
// -----------------------------------------------------------------------------
module serial_eq_cmp #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       bit_valid,
    input  logic                       a_bit,
    input  logic                       b_bit,
    output logic                       busy,
    output logic                       done,
    output logic                       eq,
    output logic [$clog2(WIDTH)-1:0]   first_diff,
    output logic [$clog2(WIDTH+1)-1:0] mismatch_cnt
);

    localparam int unsigned IdxW = $clog2(WIDTH);
    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e          state;
    logic [IdxW-1:0] bit_idx;
    logic            mismatch;

    // XNOR match; a mismatch is simply the XOR of the pair.
    assign mismatch = a_bit ^ b_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StIdle;
            busy         <= 1'b0;
            done         <= 1'b0;
            eq           <= 1'b0;
            first_diff   <= '0;
            mismatch_cnt <= '0;
            bit_idx      <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        state        <= StRun;
                        busy         <= 1'b1;
                        eq           <= 1'b1;
                        first_diff   <= '0;
                        mismatch_cnt <= '0;
                        bit_idx      <= '0;
                    end
                end

                StRun: begin
                    // start is ignored here; bit_valid=0 simply holds everything.
                    if (bit_valid) begin
                        if (mismatch) begin
                            mismatch_cnt <= mismatch_cnt + CntW'(1);
                            // eq still high means no earlier mismatch this frame.
                            if (eq) begin
                                first_diff <= bit_idx;
                                eq         <= 1'b0;
                            end
                        end
                        if (bit_idx == LastIdx) begin
                            state <= StDone;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + IdxW'(1);
                        end
                    end
                end

                StDone: begin
                    done <= 1'b0;
                    if (start) begin
                        // Back-to-back frame: skip IDLE, clear results now.
                        state        <= StRun;
                        busy         <= 1'b1;
                        eq           <= 1'b1;
                        first_diff   <= '0;
                        mismatch_cnt <= '0;
                        bit_idx      <= '0;
                    end else begin
                        state <= StIdle;
                    end
                end

                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
